// File: rtl/col_addr_skid_buf_pkg.sv
// rtl/col_addr_skid_buf_pkg.sv - shared types and constants for the SCU.memShare() column-address skid buffer
//
// Purpose: holds the skid FSM state type, the column-address type and the
//          allocation-sequence counter width used by col_addr_skid_buf and alloc_seq_cnt.
// Ports:   none (package).
package memShare_pkg;

  localparam int LANE_NUM_DEF          = 4;
  localparam int ADDR_W                = 5;
  localparam int MAX_ALLOC_SEQ_NUM_DEF = 2;
  localparam int CNT_W_DEF             = 8;

  // The counter must hold MAX_ALLOC_SEQ_NUM+1 so an over-limit accept is still
  // distinguishable from a legal one.
  function automatic int seqCntWidth(input int maxSeq);
    return (maxSeq + 2 > 2) ? $clog2(maxSeq + 2) : 1;
  endfunction

  localparam int SEQ_CNT_W = seqCntWidth(MAX_ALLOC_SEQ_NUM_DEF);

  typedef enum logic [1:0] {EMPTY, MAIN, FULL} skid_state_t;

  typedef logic [ADDR_W-1:0] col_addr_t;

endpackage

// File: rtl/col_addr_skid_buf_if.sv
// rtl/col_addr_skid_buf_if.sv - upstream/downstream column-address handshake bundle
//
// Purpose: groups the request-generator side (col_addr_i/vld_i/rdy_o) and the
//          shared-memory-port side (col_addr_o/vld_o/rdy_i) of the skid buffer.
// Modports:
//   master - the environment: drives col_addr_i, col_addr_vld_i, col_addr_rdy_i
//   slave  - the skid buffer: drives col_addr_o, col_addr_vld_o, col_addr_rdy_o
interface col_addr_skid_buf_if #(
  parameter int LANE_NUM = 4,
  parameter int ADDR_W   = 5
);

  logic [LANE_NUM*ADDR_W-1:0] col_addr_i;
  logic                       col_addr_vld_i;
  logic                       col_addr_rdy_o;
  logic [LANE_NUM*ADDR_W-1:0] col_addr_o;
  logic                       col_addr_vld_o;
  logic                       col_addr_rdy_i;

  modport master (
    output col_addr_i,
    output col_addr_vld_i,
    output col_addr_rdy_i,
    input  col_addr_rdy_o,
    input  col_addr_o,
    input  col_addr_vld_o
  );

  modport slave (
    input  col_addr_i,
    input  col_addr_vld_i,
    input  col_addr_rdy_i,
    output col_addr_rdy_o,
    output col_addr_o,
    output col_addr_vld_o
  );

endinterface

// File: rtl/col_addr_skid_buf_alloc_seq_cnt.sv
// rtl/col_addr_skid_buf_alloc_seq_cnt.sv - allocation-sequence counter for one memShare() pipeline cycle
//
// Purpose: counts accepted addresses inside a pipeline cycle, reloads on
//          pipeCycle_begin and flags an accept that exceeds MAX_ALLOC_SEQ_NUM.
// Ports:
//   sys_clk        in   clock
//   rstn           in   synchronous active-low reset
//   accept         in   an address is accepted this cycle
//   pipeCycleBegin in   first cycle of a pipeline cycle
//   seqOvf         out  combinational: this cycle's accept breaks the sequence limit
module alloc_seq_cnt
  import memShare_pkg::*;
#(
  parameter int MAX_ALLOC_SEQ_NUM = MAX_ALLOC_SEQ_NUM_DEF
) (
  input  logic sys_clk,
  input  logic rstn,
  input  logic accept,
  input  logic pipeCycleBegin,
  output logic seqOvf
);

  localparam int CW = seqCntWidth(MAX_ALLOC_SEQ_NUM);
  localparam logic [CW-1:0] MAX_VAL = CW'(MAX_ALLOC_SEQ_NUM);
  localparam logic [CW-1:0] SAT_VAL = CW'(MAX_ALLOC_SEQ_NUM + 1);

  logic [CW-1:0] seqCnt;

  // The begin cycle counts as the first of the new sequence, so an accept
  // there can only overflow a zero limit.
  always_comb begin
    seqOvf = 1'b0;
    if (accept) begin
      if (pipeCycleBegin) seqOvf = (MAX_ALLOC_SEQ_NUM < 1);
      else                seqOvf = (seqCnt >= MAX_VAL);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      seqCnt <= '0;
    end else if (pipeCycleBegin) begin
      seqCnt <= accept ? CW'(1) : '0;
    end else if (accept && (seqCnt != SAT_VAL)) begin
      seqCnt <= seqCnt + 1'b1;
    end
  end

endmodule

// File: rtl/col_addr_skid_buf.sv
// rtl/col_addr_skid_buf.sv - column-address skid buffer feeding the shared-memory port
//
// Purpose: two-entry (main + skid) in-order buffer; isColAddr_skid_i holds the
//          output and parks the arriving address in the skid register.
// Build option: SKID_BUF_STALL_CNT_EN - when defined, stall_cnt_o counts cycles
//               spent in FULL (saturating); otherwise it is tied to 0.
// Ports:
//   sys_clk           in   clock
//   rstn              in   synchronous active-low reset
//   bus               if   slave modport: col_addr_i/vld_i/rdy_o, col_addr_o/vld_o/rdy_i
//   isColAddr_skid_i  in   1 = hold output this cycle
//   pipeCycle_begin_i in   first cycle of a pipeline cycle
//   skid_occupied_o   out  skid register holds data
//   seq_err_o         out  sticky protocol error
//   stall_cnt_o       out  cycles spent in FULL
module col_addr_skid_buf
  import memShare_pkg::*;
#(
  parameter int LANE_NUM          = LANE_NUM_DEF,
  parameter int ADDR_W            = 5,
  parameter int MAX_ALLOC_SEQ_NUM = MAX_ALLOC_SEQ_NUM_DEF,
  parameter int CNT_W             = CNT_W_DEF
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  col_addr_skid_buf_if.slave   bus,
  input  logic                 isColAddr_skid_i,
  input  logic                 pipeCycle_begin_i,
  output logic                 skid_occupied_o,
  output logic                 seq_err_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  localparam int DW = LANE_NUM * ADDR_W;

  skid_state_t   state;
  skid_state_t   nextState;
  logic [DW-1:0] mainReg;
  logic [DW-1:0] skidReg;
  logic          rdyReg;
  logic          errReg;

  logic accept;
  logic pop;
  logic overflow;
  logic seqOvf;
  logic rule3Err;

  assign accept   = bus.col_addr_vld_i & rdyReg;
  assign pop      = (state != EMPTY) & bus.col_addr_rdy_i & ~isColAddr_skid_i;
  // Offered while not ready: the address is dropped and flagged.
  assign overflow = bus.col_addr_vld_i & ~rdyReg;
  // The skid selector must never coincide with a pipeline-cycle start.
  assign rule3Err = isColAddr_skid_i & pipeCycle_begin_i;

  alloc_seq_cnt #(
    .MAX_ALLOC_SEQ_NUM (MAX_ALLOC_SEQ_NUM)
  ) u_alloc_seq_cnt (
    .sys_clk        (sys_clk),
    .rstn           (rstn),
    .accept         (accept),
    .pipeCycleBegin (pipeCycle_begin_i),
    .seqOvf         (seqOvf)
  );

  always_comb begin
    nextState = state;
    case (state)
      EMPTY: if (accept) nextState = MAIN;
      MAIN: begin
        if (accept && !pop)      nextState = FULL;
        else if (!accept && pop) nextState = EMPTY;
      end
      FULL:    if (pop) nextState = MAIN;
      default: nextState = EMPTY;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state   <= EMPTY;
      mainReg <= '0;
      skidReg <= '0;
      rdyReg  <= 1'b1;
      errReg  <= 1'b0;
    end else begin
      state <= nextState;
      // Ready is registered from the next state so FULL never sees an accept.
      rdyReg <= (nextState != FULL);
      case (state)
        EMPTY: if (accept) mainReg <= bus.col_addr_i;
        MAIN: begin
          // Accept with pop replaces main directly; the skid stays unused.
          if (accept && pop) mainReg <= bus.col_addr_i;
          else if (accept)   skidReg <= bus.col_addr_i;
        end
        FULL:    if (pop) mainReg <= skidReg;
        default: ;
      endcase
      if (overflow || seqOvf || rule3Err) errReg <= 1'b1;
    end
  end

  assign bus.col_addr_o     = mainReg;
  assign bus.col_addr_vld_o = (state != EMPTY);
  assign bus.col_addr_rdy_o = rdyReg;
  assign skid_occupied_o    = (state == FULL);
  assign seq_err_o          = errReg;

`ifdef SKID_BUF_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      stallCnt <= '0;
    end else if ((state == FULL) && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign stall_cnt_o = stallCnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_col_addr_skid_buf.sv
// tb/tb_col_addr_skid_buf.sv - self-checking bench for col_addr_skid_buf
module tb_col_addr_skid_buf;

  localparam int LANE_NUM = 4;
  localparam int ADDR_W   = 5;
  localparam int DW       = LANE_NUM * ADDR_W;
  localparam int MAXS     = 2;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             sys_clk = 1'b0;
  logic             rstn;
  logic             skidSel;
  logic             pipeBegin;
  logic             skidOcc;
  logic             seqErr;
  logic [CNT_W-1:0] stallCnt;

  always #5 sys_clk = ~sys_clk;

  col_addr_skid_buf_if #(.LANE_NUM(LANE_NUM), .ADDR_W(ADDR_W)) bus ();

  col_addr_skid_buf #(
    .LANE_NUM          (LANE_NUM),
    .ADDR_W            (ADDR_W),
    .MAX_ALLOC_SEQ_NUM (MAXS),
    .CNT_W             (CNT_W)
  ) dut (
    .sys_clk           (sys_clk),
    .rstn              (rstn),
    .bus               (bus),
    .isColAddr_skid_i  (skidSel),
    .pipeCycle_begin_i (pipeBegin),
    .skid_occupied_o   (skidOcc),
    .seq_err_o         (seqErr),
    .stall_cnt_o       (stallCnt)
  );

  // Reference model: an ordered queue of at most two pending addresses.
  logic [DW-1:0] q[$];
  logic [DW-1:0] mOut;
  bit            mRdy;
  bit            mErr;
  int            mSeq;
  int            mStall;

  int nVec = 0;
  int nErr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mOut   = '0;
    mRdy   = 1'b1;
    mErr   = 1'b0;
    mSeq   = 0;
    mStall = 0;
  endtask

  task automatic modelEdge();
    bit acc;
    bit pp;
    if (!rstn) begin
      modelReset();
      return;
    end
    acc = bus.col_addr_vld_i && mRdy;
    pp  = (q.size() > 0) && bus.col_addr_rdy_i && !skidSel;
    if (q.size() == 2 && mStall < CNT_MAX) mStall++;
    if (bus.col_addr_vld_i && !mRdy) mErr = 1'b1;
    if (skidSel && pipeBegin) mErr = 1'b1;
    if (pipeBegin) begin
      if (acc && 1 > MAXS) mErr = 1'b1;
      mSeq = acc ? 1 : 0;
    end else if (acc) begin
      if (mSeq + 1 > MAXS) mErr = 1'b1;
      if (mSeq < MAXS + 1) mSeq++;
    end
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(bus.col_addr_i);
    if (q.size() > 0) mOut = q[0];
    mRdy = (q.size() < 2);
  endtask

  task automatic checkAll();
    chk("vld_o", 32'(bus.col_addr_vld_o), 32'(q.size() > 0));
    chk("col_addr_o", 32'(bus.col_addr_o), 32'(mOut));
    chk("rdy_o", 32'(bus.col_addr_rdy_o), 32'(mRdy));
    chk("skid_occupied_o", 32'(skidOcc), 32'(q.size() == 2));
    chk("seq_err_o", 32'(seqErr), 32'(mErr));
`ifdef SKID_BUF_STALL_CNT_EN
    chk("stall_cnt_o", 32'(stallCnt), 32'(mStall));
`else
    chk("stall_cnt_o", 32'(stallCnt), 32'd0);
`endif
  endtask

  // One clock: drive, take the edge, advance the model, sample 1 ns later.
  task automatic cycle(input bit vld, input logic [DW-1:0] addr, input bit rdyI,
                       input bit skid, input bit beg);
    bus.col_addr_vld_i = vld;
    bus.col_addr_i     = addr;
    bus.col_addr_rdy_i = rdyI;
    skidSel            = skid;
    pipeBegin          = beg;
    @(posedge sys_clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic doReset();
    rstn = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
  endtask

  initial begin
    modelReset();
    rstn = 1'b0;
    bus.col_addr_vld_i = 1'b0;
    bus.col_addr_i     = '0;
    bus.col_addr_rdy_i = 1'b0;
    skidSel            = 1'b0;
    pipeBegin          = 1'b0;

    // Reset state
    doReset();
    doReset();
    chk("rst_vld", 32'(bus.col_addr_vld_o), 32'd0);
    chk("rst_rdy", 32'(bus.col_addr_rdy_o), 32'd1);
    chk("rst_addr", 32'(bus.col_addr_o), 32'd0);
    chk("rst_occ", 32'(skidOcc), 32'd0);
    chk("rst_err", 32'(seqErr), 32'd0);
    chk("rst_stall", 32'(stallCnt), 32'd0);

    // Streaming 0x01..0x08, begin pulse every second accept
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, DW'(i), 1'b1, 1'b0, (i % 2) == 1);
      chk("stream_addr", 32'(bus.col_addr_o), 32'(i));
      chk("stream_occ", 32'(skidOcc), 32'd0);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("stream_drain_vld", 32'(bus.col_addr_vld_o), 32'd0);
    chk("stream_err", 32'(seqErr), 32'd0);

    // Single stall
    cycle(1'b1, DW'('h0A), 1'b1, 1'b0, 1'b1);
    chk("stall_first", 32'(bus.col_addr_o), 32'h0A);
    cycle(1'b1, DW'('h0B), 1'b1, 1'b1, 1'b0);
    chk("stall_full", 32'(skidOcc), 32'd1);
    chk("stall_rdy", 32'(bus.col_addr_rdy_o), 32'd0);
    chk("stall_hold", 32'(bus.col_addr_o), 32'h0A);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("stall_second", 32'(bus.col_addr_o), 32'h0B);
    chk("stall_occ_clr", 32'(skidOcc), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("stall_empty", 32'(bus.col_addr_vld_o), 32'd0);

    // Backpressure with overflow on the third address
    cycle(1'b1, DW'('h11), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DW'('h12), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DW'('h13), 1'b0, 1'b0, 1'b0);
    chk("bp_err", 32'(seqErr), 32'd1);
    chk("bp_hold", 32'(bus.col_addr_o), 32'h11);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp_second", 32'(bus.col_addr_o), 32'h12);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp_empty", 32'(bus.col_addr_vld_o), 32'd0);
    chk("bp_sticky", 32'(seqErr), 32'd1);
    doReset();

    // Skid selector together with begin
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("rule3_err", 32'(seqErr), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("rule3_sticky", 32'(seqErr), 32'd1);
    doReset();

    // Sequence limit: two accepts legal, third flagged
    cycle(1'b1, DW'(1), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, DW'(2), 1'b1, 1'b0, 1'b0);
    chk("seq_two_ok", 32'(seqErr), 32'd0);
    cycle(1'b1, DW'(3), 1'b1, 1'b0, 1'b0);
    chk("seq_third_err", 32'(seqErr), 32'd1);
    doReset();

    // Long FULL hold (stall counter saturation), then reset while FULL
    cycle(1'b1, DW'(1), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, DW'(2), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 260; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("full_occ", 32'(skidOcc), 32'd1);
`ifdef SKID_BUF_STALL_CNT_EN
    chk("stall_sat", 32'(stallCnt), 32'(CNT_MAX));
`endif
    doReset();
    chk("rfull_vld", 32'(bus.col_addr_vld_o), 32'd0);
    chk("rfull_rdy", 32'(bus.col_addr_rdy_o), 32'd1);
    chk("rfull_occ", 32'(skidOcc), 32'd0);
    chk("rfull_stall", 32'(stallCnt), 32'd0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 2000; i++) begin
      bit vld;
      bit skd;
      bit beg;
      if ((i % 60) == 59) begin
        doReset();
      end else begin
        beg = ($urandom_range(0, 2) == 0);
        skd = beg ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 4) == 0);
        vld = ($urandom_range(0, 3) != 0) && (mRdy || ($urandom_range(0, 9) == 0));
        cycle(vld, DW'($urandom()), $urandom_range(0, 9) < 7, skd, beg);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
